// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter; grant moves only at legal handover points, 1-cycle arbitration.
// HREADY=0 freezes all state except an error response, which aborts the burst tracking.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MST_W          = 2,
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic                   HRSP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MST_W-1:0]       HMASTER,
    output logic                   HMASTLOCK,
    output logic [1:0]             ARB_STATE
);

    typedef enum logic [1:0] {
        PARK      = 2'b00,
        OWNED     = 2'b01,
        FIXBURST  = 2'b10,
        INCRBURST = 2'b11
    } state_t;

    localparam logic [4:0] INCR_MAX = 5'(MAX_INCR_BEATS);

    state_t                   state_q, state_d;
    logic [3:0]               beat_cnt_q, beat_cnt_d;
    logic [4:0]               incr_cnt_q, incr_cnt_d;
    logic [MST_W-1:0]         hmaster_q, hmaster_d;
    logic [NUM_MASTERS-1:0]   hgrant_q, hgrant_d;
    logic                     hmastlock_q, hmastlock_d;

    logic                     found;
    logic [MST_W-1:0]         winner;
    logic [MST_W-1:0]         cand;
    logic                     is_nonseq, is_seq, final_beat, elig;

    // Scan starts just after the current owner so the owner itself is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MST_W'((int'(hmaster_q) + k) % NUM_MASTERS);
            if (!found && HBUSREQ[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        incr_cnt_d  = incr_cnt_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        is_nonseq   = (HTRANS == 2'b10);
        is_seq      = (HTRANS == 2'b11);
        final_beat  = (state_q == FIXBURST) && (beat_cnt_q == 4'd1) && is_seq;
        elig        = 1'b0;

        if (HREADY) begin
            if (is_nonseq) begin
                unique case (HBURST)
                    3'b001: begin
                        state_d    = INCRBURST;
                        incr_cnt_d = '0;
                    end
                    3'b010, 3'b011: begin
                        state_d    = FIXBURST;
                        beat_cnt_d = 4'd3;
                    end
                    3'b100, 3'b101: begin
                        state_d    = FIXBURST;
                        beat_cnt_d = 4'd7;
                    end
                    3'b110, 3'b111: begin
                        state_d    = FIXBURST;
                        beat_cnt_d = 4'd15;
                    end
                    default: state_d = OWNED;
                endcase
            end else if (state_q == FIXBURST) begin
                if (is_seq) begin
                    if (beat_cnt_q == 4'd1) begin
                        state_d    = OWNED;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end
            end else if (state_q == INCRBURST) begin
                if (is_seq) begin
                    if (incr_cnt_q != INCR_MAX) incr_cnt_d = incr_cnt_q + 5'd1;
                end else if (HTRANS == 2'b00) begin
                    state_d = OWNED;
                end
            end

            elig = !HLOCK[hmaster_q] &&
                   ((((state_q == PARK) || (state_q == OWNED)) && !is_nonseq) ||
                    final_beat ||
                    ((state_q == INCRBURST) && (incr_cnt_q == INCR_MAX)));

            if (elig) begin
                if (!found) begin
                    hmaster_d  = '0;
                    state_d    = PARK;
                    beat_cnt_d = '0;
                    incr_cnt_d = '0;
                end else if (winner != hmaster_q) begin
                    hmaster_d  = winner;
                    state_d    = OWNED;
                    beat_cnt_d = '0;
                    incr_cnt_d = '0;
                end else if (state_q == INCRBURST) begin
                    // Sole requester at the fairness limit keeps bursting with a fresh budget.
                    state_d    = INCRBURST;
                    incr_cnt_d = '0;
                end else begin
                    state_d = OWNED;
                end
            end

            hmastlock_d = HLOCK[hmaster_d];
        end else if (HRSP) begin
            state_d    = OWNED;
            beat_cnt_d = '0;
            incr_cnt_d = '0;
        end
    end

    always_comb begin
        hgrant_d            = '0;
        hgrant_d[hmaster_d] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= PARK;
            beat_cnt_q  <= '0;
            incr_cnt_q  <= '0;
            hmaster_q   <= '0;
            hgrant_q    <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            incr_cnt_q  <= incr_cnt_d;
            hmaster_q   <= hmaster_d;
            hgrant_q    <= hgrant_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;
    assign ARB_STATE = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed handover scenarios plus randomized traffic against a behavioural model.
module tb_ahb_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 16;

    logic         HCLK;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic         HRSP;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic         HMASTLOCK;
    logic [1:0]   ARB_STATE;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index, mode (0 park,1 owned,2 fixed burst,3 incr burst), beats left, incr beats seen.
    int m_owner, m_mode, m_left, m_incr, m_lock;

    ahb_arbiter #(.NUM_MASTERS(N), .MST_W(2), .MAX_INCR_BEATS(MAXB)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRSP(HRSP),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .ARB_STATE(ARB_STATE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic model_reset();
        m_owner = 0; m_mode = 0; m_left = 0; m_incr = 0; m_lock = 0;
    endtask

    task automatic model_step();
        int mode, left, incr, win;
        bit eligible;
        mode = m_mode; left = m_left; incr = m_incr; win = -1;
        if (HREADY) begin
            eligible = (HLOCK[m_owner] == 1'b0) &&
                       ((m_mode <= 1 && HTRANS != 2) ||
                        (m_mode == 2 && m_left == 1 && HTRANS == 3) ||
                        (m_mode == 3 && m_incr == MAXB));
            if (HTRANS == 2) begin
                if (HBURST == 1) begin mode = 3; incr = 0; end
                else if (HBURST >= 2) begin mode = 2; left = (HBURST <= 3) ? 3 : (HBURST <= 5) ? 7 : 15; end
                else mode = 1;
            end else if (m_mode == 2 && HTRANS == 3) begin
                left = left - 1;
                if (left == 0) mode = 1;
            end else if (m_mode == 3) begin
                if (HTRANS == 3) incr = (incr < MAXB) ? incr + 1 : MAXB;
                else if (HTRANS == 0) mode = 1;
            end
            if (eligible) begin
                for (int k = 1; k <= N; k++) begin
                    if (HBUSREQ[(m_owner + k) % N]) begin
                        win = (m_owner + k) % N;
                        break;
                    end
                end
                if (win < 0) begin
                    m_owner = 0; mode = 0; left = 0; incr = 0;
                end else if (win != m_owner) begin
                    m_owner = win; mode = 1; left = 0; incr = 0;
                end else if (m_mode == 3) begin
                    mode = 3; incr = 0;
                end else begin
                    mode = 1;
                end
            end
            m_lock = HLOCK[m_owner];
        end else if (HRSP) begin
            mode = 1; left = 0; incr = 0;
        end
        m_mode = mode; m_left = left; m_incr = incr;
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [1:0] tr, input logic [2:0] bu);
        HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY = 1'b1; HRSP = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (HGRANT !== 4'b0001) begin failures++; $display("FAIL reset_grant got=%b exp=0001", HGRANT); end
        checks++;
        if (HMASTER !== 2'd0) begin failures++; $display("FAIL reset_master got=%0d exp=0", HMASTER); end
        checks++;
        if (HMASTLOCK !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", HMASTLOCK); end
        checks++;
        if (ARB_STATE !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", ARB_STATE); end
    endtask

    task automatic test_reset_mid_burst();
        drive(4'b0010, 2'b00, 3'b000); tick();
        drive(4'b0010, 2'b10, 3'b101); tick();
        drive(4'b0010, 2'b11, 3'b101); tick();
        tick();
        checks++;
        if (ARB_STATE !== 2'b10 || HMASTER !== 2'd1) begin
            failures++; $display("FAIL midburst_pre state=%b master=%0d exp=10/1", ARB_STATE, HMASTER);
        end
        #2 HRESET = 1'b0;
        #1 model_reset();
        checks++;
        if (HGRANT !== 4'b0001 || HMASTER !== 2'd0 || ARB_STATE !== 2'b00) begin
            failures++; $display("FAIL async_reset grant=%b master=%0d state=%b exp=0001/0/00", HGRANT, HMASTER, ARB_STATE);
        end
        HBUSREQ = '0; HTRANS = 2'b00;
        #2 HRESET = 1'b1;
        tick();
        checks++;
        if (HMASTER !== 2'd0 || ARB_STATE !== 2'b00) begin
            failures++; $display("FAIL post_reset_park master=%0d state=%b exp=0/00", HMASTER, ARB_STATE);
        end
        drive(4'b0010, 2'b00, 3'b000); tick();
        checks++;
        if (HMASTER !== 2'd1) begin failures++; $display("FAIL rerequest master=%0d exp=1", HMASTER); end
    endtask

    task automatic test_rotation();
        int exp_order[4] = '{2, 3, 0, 1};
        drive(4'b0010, 2'b00, 3'b000); tick();
        drive(4'b1111, 2'b00, 3'b000);
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] one;
            tick();
            one = '0;
            one[exp_order[i]] = 1'b1;
            checks++;
            if (HMASTER !== 2'(exp_order[i]) || HGRANT !== one) begin
                failures++; $display("FAIL rotation step%0d master=%0d grant=%b exp=%0d/%b", i, HMASTER, HGRANT, exp_order[i], one);
            end
        end
    endtask

    task automatic test_fixburst();
        drive(4'b0010, 2'b00, 3'b000); tick();
        drive(4'b0110, 2'b10, 3'b010); tick();
        drive(4'b0110, 2'b11, 3'b010); tick();
        drive(4'b0110, 2'b01, 3'b010); tick();
        drive(4'b0110, 2'b11, 3'b010); HREADY = 1'b0; tick();
        drive(4'b0110, 2'b11, 3'b010); tick();
        checks++;
        if (HMASTER !== 2'd1 || ARB_STATE !== 2'b10) begin
            failures++; $display("FAIL incr4_tenure master=%0d state=%b exp=1/10", HMASTER, ARB_STATE);
        end
        tick();
        checks++;
        if (HMASTER !== 2'd2 || HGRANT !== 4'b0100 || ARB_STATE !== 2'b01) begin
            failures++; $display("FAIL incr4_handover master=%0d grant=%b state=%b exp=2/0100/01", HMASTER, HGRANT, ARB_STATE);
        end
    endtask

    task automatic test_incr_limit();
        drive(4'b1000, 2'b00, 3'b000); tick();
        drive(4'b1111, 2'b10, 3'b001); tick();
        drive(4'b1111, 2'b11, 3'b001);
        repeat (MAXB) tick();
        checks++;
        if (HMASTER !== 2'd3 || ARB_STATE !== 2'b11) begin
            failures++; $display("FAIL incr_hold master=%0d state=%b exp=3/11", HMASTER, ARB_STATE);
        end
        tick();
        checks++;
        if (HMASTER !== 2'd0 || ARB_STATE !== 2'b01) begin
            failures++; $display("FAIL incr_limit master=%0d state=%b exp=0/01", HMASTER, ARB_STATE);
        end
        drive(4'b0001, 2'b00, 3'b000); tick();
    endtask

    task automatic test_lock();
        drive(4'b0001, 2'b00, 3'b000); HLOCK = '0; tick();
        HLOCK = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0011, 2'b10, 3'b000); tick();
            drive(4'b0011, 2'b00, 3'b000); tick();
            checks++;
            if (HMASTER !== 2'd0 || HMASTLOCK !== 1'b1) begin
                failures++; $display("FAIL locked%0d master=%0d mlock=%b exp=0/1", i, HMASTER, HMASTLOCK);
            end
        end
        HLOCK = '0; tick();
        checks++;
        if (HMASTER !== 2'd1 || HMASTLOCK !== 1'b0) begin
            failures++; $display("FAIL lock_release master=%0d mlock=%b exp=1/0", HMASTER, HMASTLOCK);
        end
    endtask

    task automatic test_error();
        drive(4'b0100, 2'b00, 3'b000); tick();
        drive(4'b0101, 2'b10, 3'b100); tick();
        drive(4'b0101, 2'b11, 3'b100); tick();
        drive(4'b0101, 2'b11, 3'b100); HREADY = 1'b0; HRSP = 1'b1; tick();
        checks++;
        if (ARB_STATE !== 2'b01 || dut.beat_cnt_q !== 4'd0 || HMASTER !== 2'd2) begin
            failures++; $display("FAIL error_abort state=%b beat=%0d master=%0d exp=01/0/2", ARB_STATE, dut.beat_cnt_q, HMASTER);
        end
        drive(4'b0101, 2'b00, 3'b000); tick();
        checks++;
        if (HMASTER !== 2'd0 || HGRANT !== 4'b0001) begin
            failures++; $display("FAIL error_handover master=%0d grant=%b exp=0/0001", HMASTER, HGRANT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] lk;
            HBUSREQ = N'($urandom);
            for (int b = 0; b < N; b++) lk[b] = ($urandom_range(0, 15) == 0);
            HLOCK  = lk;
            HTRANS = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom);
            HBURST = 3'($urandom);
            HREADY = ($urandom_range(0, 3) != 0);
            HRSP   = !HREADY && ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (HGRANT !== N'(1 << m_owner) || HMASTER !== 2'(m_owner) ||
                HMASTLOCK !== 1'(m_lock) || ARB_STATE !== 2'(m_mode)) begin
                failures++;
                $display("FAIL random%0d grant=%b master=%0d mlock=%b state=%b exp master=%0d mlock=%0d state=%0d",
                         i, HGRANT, HMASTER, HMASTLOCK, ARB_STATE, m_owner, m_lock, m_mode);
            end
        end
    endtask

    initial begin
        HRESET = 1'b0;
        HBUSREQ = '0; HLOCK = '0; HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1; HRSP = 1'b0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        test_reset();
        #3 HRESET = 1'b1;
        test_reset_mid_burst();
        test_rotation();
        test_fixburst();
        test_incr_limit();
        test_lock();
        test_error();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares the single AHB-Lite memory slave between up to NUM_MASTERS requesters. It sits ahead of the master-side address/data mux, tracks burst progress from the muxed HTRANS/HBURST and the slave's HREADY/HRSP, and moves the grant only at legal handover points. Locked sequences, fixed-length bursts and error aborts are honoured. Undefined-length INCR bursts are bounded by a fairness limit.

## Interface
- NUM_MASTERS, 4: number of requesters (2..8)
- MST_W, 2: width of HMASTER, equal to $clog2(NUM_MASTERS)
- MAX_INCR_BEATS, 16: SEQ beats of an undefined-length INCR burst before the grant may move

- HCLK  in  1  clock, rising edge
- HRESET  in  1  reset, asynchronous, active-low
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master lock request
- HTRANS  in  2  muxed transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HBURST  in  3  muxed burst type
- HREADY  in  1  slave ready
- HRSP  in  1  slave error response
- HGRANT  out  NUM_MASTERS  one-hot grant
- HMASTER  out  MST_W  index of the granted master
- HMASTLOCK  out  1  registered HLOCK[HMASTER]
- ARB_STATE  out  2  current FSM state, for debug

## Operation
- FSM states: PARK=00 (no owner, master 0 parked), OWNED=01 (owner between transfers), FIXBURST=10 (fixed burst in progress), INCRBURST=11 (undefined-length INCR in progress).
- Registers: `beat_cnt` (4 bits, fixed-burst beats remaining), `incr_cnt` (5 bits, saturating), `HMASTER`, `HGRANT`.
- All state updates occur only on edges with HREADY=1, except error handling.
- HTRANS=NONSEQ starts a burst:
  - HBURST SINGLE (000): FSM goes to OWNED.
  - INCR4/WRAP4: beat_cnt=3, FSM goes to FIXBURST.
  - INCR8/WRAP8: beat_cnt=7, FSM goes to FIXBURST.
  - INCR16/WRAP16: beat_cnt=15, FSM goes to FIXBURST.
  - INCR (001): incr_cnt=0, FSM goes to INCRBURST.
- In FIXBURST:
  - SEQ decrements beat_cnt.
  - BUSY or IDLE holds beat_cnt.
  - The SEQ accepted while beat_cnt=1 returns the FSM to OWNED.
- In INCRBURST:
  - SEQ increments incr_cnt, saturating at MAX_INCR_BEATS.
  - IDLE ends the burst and the FSM goes to OWNED.
  - NONSEQ restarts burst decoding.
- Handover eligible (elig) when HREADY=1, HLOCK[HMASTER]=0, and one of the following holds:
  - FSM is PARK or OWNED, with HTRANS not NONSEQ.
  - The FSM is on the final FIXBURST beat.
  - FSM is INCRBURST with incr_cnt=MAX_INCR_BEATS.
- When elig, the winner is the first requester scanning HMASTER+1, HMASTER+2, … wrapping modulo NUM_MASTERS, with HMASTER itself checked last.
  - With a winner: HGRANT and HMASTER update at that edge and the FSM goes to OWNED.
  - A new master resets incr_cnt and beat_cnt to 0.
  - With no requester: grant parks on master 0 and the FSM goes to PARK.
  - If the winner equals the current owner during INCRBURST at the limit, the FSM stays in INCRBURST and incr_cnt restarts at 0.
- Error: HRSP=1 with HREADY=0 clears beat_cnt and incr_cnt and forces OWNED. The grant is held until the next HREADY=1 edge, which is then elig unless the owner is locked.
- HMASTLOCK is registered on every HREADY=1 edge as HLOCK[next HMASTER].
- A locked owner keeps the grant regardless of other requests. The lock releases on the first HREADY=1 edge where HLOCK[HMASTER]=0 and elig holds.
- Writes to HBURST encodings that are not listed are treated as SINGLE.

## Timing
- Reset values:
  - HGRANT = 1 (master 0)
  - HMASTER = 0
  - HMASTLOCK = 0
  - ARB_STATE = PARK
  - beat_cnt = 0
  - incr_cnt = 0
- Latency: a request sampled at edge N is reflected in HGRANT/HMASTER after edge N when elig, so arbitration is 1 cycle.
- HGRANT is always one-hot and always equals 1<<HMASTER.
- With HREADY=0 (no error), all outputs hold.
- Reset asserted mid-burst returns to the reset values immediately. No partial state survives reset.
- Simultaneous final burst beat and new requests: the handover occurs on that same edge.
- An error on the final fixed beat follows the error rule.

## Test plan
- Reset mid-FIXBURST of an INCR8 (after 3 beats) -> HGRANT=0001, HMASTER=0 and ARB_STATE=00 asynchronously; after release, M1 is granted again only after re-requesting.
- Master 1 requests alone, then HBUSREQ=1111 with HREADY=1 and IDLE traffic -> grant order M2, M3, M0, M1, one per cycle, HGRANT one-hot throughout.
- M1 issues INCR4 (NONSEQ + 3 SEQ) while M2 requests -> HMASTER stays 1 through beat 4 and becomes 2 on the edge accepting the 4th beat; BUSY cycles and HREADY=0 stalls extend the tenure.
- M3 issues INCR with HLOCK[3]=0, 20 SEQ beats, others requesting -> grant moves after 16 SEQ beats (MAX_INCR_BEATS=16).
- M0 holds HLOCK=1 across 3 SINGLE transfers while M1 requests -> HMASTLOCK=1 and HMASTER=0 throughout; after HLOCK drops, M1 is granted on the next HREADY=1 edge.
- M2 in INCR8 with 2nd-beat HRSP=1/HREADY=0 -> ARB_STATE=01 and beat_cnt=0; with M0 requesting, grant moves to M0 on the following HREADY=1 edge.
